// File: rtl/gearbox_2x1_pkt_arb_pkg.sv
// gearbox_2x1_pkt_arb_pkg: shared FSM state type and port-index width helper
// No ports; imported by gearbox_2x1_rr_sel and gearbox_2x1_pkt_arb.
package gearbox_2x1_pkt_arb_pkg;
  typedef enum logic {IDLE, PASS} state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gearbox_2x1_rr_sel.sv
// gearbox_2x1_rr_sel: combinational round-robin pick of the first request after last_i
// req_i  : request vector, one bit per port
// last_i : index of the previously granted port
// vld_o  : any request present
// idx_o  : winning port index
module gearbox_2x1_rr_sel
  import gearbox_2x1_pkt_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);
  int j;
  assign vld_o = |req_i;
  // Scan farthest-first so the closest requester after last_i is written last and wins.
  always_comb begin
    idx_o = '0;
    j = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last_i) + k) % N;
      if (req_i[j]) idx_o = IW'(j);
    end
  end
endmodule

// File: rtl/gearbox_2x1_pkt_arb.sv
// gearbox_2x1_pkt_arb: packet-level round-robin arbiter feeding one gearbox_2x1 input
// s_tdata/s_tlast/s_tvalid/s_tready : NUM_PORTS AXI-Stream requesters, port p at slice p
// m_tdata/m_tlast/m_tvalid/m_tready : registered stream toward the gearbox
// m_tdest      : source port of the beat on m_tdata
// grant_active : high while a packet is in progress
module gearbox_2x1_pkt_arb
  import gearbox_2x1_pkt_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int WORD_W    = 32,
  parameter int IN_WORDS  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS*IN_WORDS*WORD_W-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]                 s_tlast,
  input  logic [NUM_PORTS-1:0]                 s_tvalid,
  output logic [NUM_PORTS-1:0]                 s_tready,
  output logic [IN_WORDS*WORD_W-1:0]           m_tdata,
  output logic                                 m_tlast,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic [$clog2(NUM_PORTS)-1:0]         m_tdest,
  output logic                                 grant_active
);
  localparam int BW = IN_WORDS * WORD_W;
  localparam int IW = idx_w(NUM_PORTS);
  state_e state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, sel_idx;
  logic sel_vld, out_ok, acc;
  logic [BW-1:0] m_tdata_q;
  logic m_tlast_q, m_tvalid_q;
  logic [IW-1:0] m_tdest_q;
  gearbox_2x1_rr_sel #(.N(NUM_PORTS), .IW(IW)) u_sel (
    .req_i (s_tvalid),
    .last_i(last_q),
    .vld_o (sel_vld),
    .idx_o (sel_idx)
  );
  // Output slot can take a beat when empty or being drained this cycle.
  assign out_ok       = !m_tvalid_q || m_tready;
  assign acc          = state_q == PASS && out_ok && s_tvalid[grant_q];
  assign s_tready     = (state_q == PASS && out_ok) ? NUM_PORTS'(1) << grant_q : '0;
  assign grant_active = state_q == PASS;
  assign m_tdata      = m_tdata_q;
  assign m_tlast      = m_tlast_q;
  assign m_tvalid     = m_tvalid_q;
  assign m_tdest      = m_tdest_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (state_q == IDLE && sel_vld) begin
      state_d = PASS;
      grant_d = sel_idx;
      last_d  = sel_idx;
    end else if (acc && s_tlast[grant_q]) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IW'(NUM_PORTS - 1);
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdest_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      if (acc) begin
        m_tdata_q  <= s_tdata[int'(grant_q)*BW +: BW];
        m_tlast_q  <= s_tlast[grant_q];
        m_tvalid_q <= 1'b1;
        m_tdest_q  <= grant_q;
      end else if (m_tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gearbox_2x1_pkt_arb.sv
// tb_gearbox_2x1_pkt_arb: scoreboard bench for the packet round-robin arbiter
module tb_gearbox_2x1_pkt_arb;
  localparam int NP = 4;
  localparam int BW = 64;
  typedef struct packed {logic last; logic [BW-1:0] data;} beat_t;
  typedef struct packed {logic [BW-1:0] data; logic last; logic [1:0] dest;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP*BW-1:0] s_tdata;
  logic [NP-1:0] s_tlast, s_tvalid, s_tready;
  logic [BW-1:0] m_tdata;
  logic m_tlast, m_tvalid, m_tready;
  logic [1:0] m_tdest;
  logic grant_active;
  beat_t src_q [NP][$];
  exp_t sb[$];
  logic [NP-1:0] hold = '0;
  logic [NP-1:0] acc = '0;
  int n_vec = 0;
  int n_err = 0;
  logic stall = 1'b0;
  logic [BW-1:0] pd;
  logic pl;
  logic [1:0] pt;
  exp_t e;
  always #5 clk = ~clk;
  gearbox_2x1_pkt_arb #(.NUM_PORTS(NP), .WORD_W(32), .IN_WORDS(2)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdest(m_tdest), .grant_active(grant_active)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] mk(input int p, input int k, input int b);
    return {8'hA5, 8'(p), 16'(k), 16'(b), 16'h5A3C};
  endfunction
  function automatic int pending();
    int n = sb.size();
    for (int p = 0; p < NP; p++) n += src_q[p].size();
    return n;
  endfunction
  task automatic send(input int p, input int k, input int nb, input int ne);
    beat_t b;
    exp_t x;
    for (int i = 0; i < nb; i++) begin
      b.last = (i == nb - 1);
      b.data = mk(p, k, i);
      src_q[p].push_back(b);
      if (i < ne) begin
        x.data = b.data;
        x.last = b.last;
        x.dest = 2'(p);
        sb.push_back(x);
      end
    end
  endtask
  task automatic drain(input string tag);
    int t = 0;
    while (pending() > 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    check(tag, 64'(pending()), 0);
    repeat (2) @(posedge clk);
    #2;
  endtask
  task automatic wait_src(input int p, input int n, input string tag);
    int t = 0;
    while (src_q[p].size() != n && t < 50) begin
      @(posedge clk);
      #2;
      t++;
    end
    check(tag, 64'(src_q[p].size()), 64'(n));
  endtask
  initial begin
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        s_tvalid[p] = src_q[p].size() > 0 && !hold[p];
        s_tlast[p]  = src_q[p].size() > 0 ? src_q[p][0].last : 1'b0;
        s_tdata[p*BW +: BW] = src_q[p].size() > 0 ? src_q[p][0].data : '0;
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      acc = s_tvalid & s_tready;
      if (rst) stall = 1'b0;
      check("rdy_onehot", 64'($onehot0(s_tready)), 1);
      if (stall) begin
        check("hold_data", m_tdata, pd);
        check("hold_last", 64'(m_tlast), 64'(pl));
        check("hold_dest", 64'(m_tdest), 64'(pt));
      end
      if (m_tvalid && m_tready) begin
        check("sb_nonempty", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("beat_data", m_tdata, e.data);
          check("beat_last", 64'(m_tlast), 64'(e.last));
          check("beat_dest", 64'(m_tdest), 64'(e.dest));
        end
      end
      stall = m_tvalid && !m_tready;
      pd = m_tdata;
      pl = m_tlast;
      pt = m_tdest;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end
  initial begin
    int t;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", 64'(s_tready), 0);
    check("rst_m_tvalid", 64'(m_tvalid), 0);
    check("rst_m_tlast", 64'(m_tlast), 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tdest", 64'(m_tdest), 0);
    check("rst_active", 64'(grant_active), 0);
    @(negedge clk);
    rst = 1'b0;
    // all ports busy: 0,1,2,3,0 with one idle cycle between packets
    @(posedge clk);
    #2;
    send(0, 0, 2, 2);
    send(1, 0, 2, 2);
    send(2, 0, 2, 2);
    send(3, 0, 2, 2);
    send(0, 1, 2, 2);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m_tvalid && t < 20);
    check("t2_start", 64'(m_tvalid), 1);
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      check("t2_gap", 64'(m_tvalid), 64'((i % 3) != 2));
    end
    drain("t2_drain");
    // port 2 alone, 3-beat packet, exact latency
    send(2, 0, 3, 3);
    @(posedge clk);
    #3;
    @(negedge clk);
    check("t1_idle_rdy", 64'(s_tready), 0);
    @(negedge clk);
    check("t1_rdy", 64'(s_tready), 64'(4'b0100));
    check("t1_active", 64'(grant_active), 1);
    check("t1_no_valid", 64'(m_tvalid), 0);
    @(negedge clk);
    check("t1_valid", 64'(m_tvalid), 1);
    check("t1_dest", 64'(m_tdest), 2);
    drain("t1_drain");
    // 5-beat packet with m_tready toggling
    send(1, 0, 5, 5);
    t = 0;
    while (pending() > 0 && t < 60) begin
      @(posedge clk);
      #2;
      m_tready = ~m_tready;
      t++;
    end
    m_tready = 1'b1;
    drain("t3_drain");
    // port 1 pauses mid-packet while port 3 requests
    send(1, 1, 4, 4);
    wait_src(1, 3, "t4_first");
    hold[1] = 1'b1;
    send(3, 0, 2, 2);
    @(negedge clk);
    repeat (4) begin
      @(negedge clk);
      check("t4_rdy", 64'(s_tready), 64'(4'b0010));
      check("t4_active", 64'(grant_active), 1);
    end
    hold[1] = 1'b0;
    drain("t4_drain");
    // single-beat packets on ports 0 and 3
    send(0, 2, 1, 1);
    send(3, 1, 1, 1);
    drain("t5_drain");
    // reset during beat 2 of a 4-beat packet
    send(2, 2, 4, 1);
    wait_src(2, 2, "t6_two_acc");
    check("t6_pre_valid", 64'(m_tvalid), 1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_m_tvalid", 64'(m_tvalid), 0);
    check("t6_s_tready", 64'(s_tready), 0);
    check("t6_active", 64'(grant_active), 0);
    check("t6_m_tdest", 64'(m_tdest), 0);
    check("t6_sb_empty", 64'(sb.size()), 0);
    for (int p = 0; p < NP; p++) src_q[p].delete();
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    send(0, 3, 1, 1);
    send(3, 2, 1, 1);
    drain("t6_drain");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gearbox_2x1_pkt_arb.md
# gearbox_2x1_pkt_arb

Packet-level round-robin arbiter that shares one gearbox_2x1 input between NUM_PORTS AXI-Stream requesters. Grants one source at a time, holds the grant until that packet's tlast is accepted, so gearbox word alignment is never disturbed mid-packet. Sits immediately upstream of gearbox_2x1 in the same clock domain as the gearbox input side.

## Interface
- NUM_PORTS, 4: number of requesting streams, 2..16.
- WORD_W, 32: bits per word.
- IN_WORDS, 2: words per beat; must match the downstream gearbox IN_WORDS.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_tdata  in  NUM_PORTS*IN_WORDS*WORD_W  per-port data, port p at slice p.
- s_tlast  in  NUM_PORTS  per-port end of packet.
- s_tvalid  in  NUM_PORTS  per-port valid.
- s_tready  out  NUM_PORTS  per-port ready; at most one bit high.
- m_tdata  out  IN_WORDS*WORD_W  to gearbox input.
- m_tlast  out  1  end of packet.
- m_tvalid  out  1  output valid.
- m_tready  in  1  gearbox ready.
- m_tdest  out  $clog2(NUM_PORTS)  index of the port that sourced the current beat.
- grant_active  out  1  high while a packet is in progress (status only).

## Operation
- States: IDLE, PASS.
- IDLE: if any s_tvalid is high, select the first requesting port searching from last_grant+1 upward modulo NUM_PORTS; register grant and last_grant, go to PASS. No s_tready asserted in IDLE.
- PASS: s_tready[grant] = !m_tvalid || m_tready; all other s_tready low. Accepted beat loads output register (m_tdata, m_tlast, m_tdest=grant, m_tvalid=1).
- Beat accepted with s_tlast=1: go to IDLE same edge; grant_active drops.
- Output register: cleared (m_tvalid=0) when m_tready=1 and no new beat is loaded; holds all fields stable while m_tvalid && !m_tready.
- A requester deasserting s_tvalid mid-packet does not lose the grant; PASS waits indefinitely.
- Single-beat packets (tlast on first beat) are legal.
- Requests arriving in PASS are ignored until return to IDLE; no starvation: every port with continuous valid is granted within NUM_PORTS packets.

## Timing
- Reset values: state IDLE, last_grant = NUM_PORTS-1 (port 0 wins first), grant 0, s_tready all 0, m_tvalid 0, m_tlast 0, m_tdata 0, m_tdest 0, grant_active 0.
- Arbitration costs exactly one cycle per packet: s_tvalid seen in IDLE at cycle n -> s_tready[grant] high at n+1 -> first beat m_tvalid at n+2.
- Within a packet: full throughput, one beat per cycle when m_tready held high; latency input accept to m_tvalid = 1 cycle.
- Simultaneous tlast accept and new requests: return to IDLE, new arbitration next cycle (no back-to-back packets without a bubble).
- rst asserted mid-packet: all outputs to reset values immediately (asynchronous); the partial packet is discarded; downstream gearbox must be reset together.

## Structure
- Package gearbox_2x1_pkt_arb_pkg: state enum (IDLE, PASS), function for port-index width.
- Sub-module gearbox_2x1_rr_sel: combinational round-robin select (request vector, last_grant -> valid, next index).

## Test plan
- Reset, port 2 only valid with 3-beat packet, m_tready=1 -> s_tready[2] at cycle 1, beats on m_tdata cycles 2-4, m_tdest=2, m_tlast on beat 3.
- All 4 ports valid continuously with 2-beat packets -> m_tdest sequence 0,1,2,3,0, one idle cycle between packets.
- m_tready toggled 1/0 per cycle during 5-beat packet -> all 5 beats delivered in order, m_tdata stable while stalled, no duplicates.
- Port 1 drops s_tvalid for 4 cycles mid-packet while port 3 requests -> grant stays on port 1 until tlast, then port 3.
- Single-beat packets on ports 0 and 3 -> m_tdest 0 then 3, each with m_tlast=1.
- rst pulsed during beat 2 of a 4-beat packet -> m_tvalid 0 and s_tready 0 immediately; after release, port 0 granted first.
